// File: rtl/rob_fill_resp.sv
// Round-robin arbiter from N reservation-station fill ports onto the single ROB
// write port, through a one-entry registered output stage with flush and back-pressure.
module rob_fill_resp #(
  parameter int N_SRC  = 3,
  parameter int IDX_W  = 5,
  parameter int DATA_W = 32,
  localparam int SRC_W = $clog2(N_SRC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [N_SRC-1:0]        fill_req,
  input  logic [N_SRC*IDX_W-1:0]  fill_idx,
  input  logic [N_SRC*DATA_W-1:0] fill_data,
  input  logic [N_SRC-1:0]        fill_exc,
  output logic [N_SRC-1:0]        fill_ack,
  input  logic                    rob_wr_rdy,
  output logic                    rob_wr_en,
  output logic [IDX_W-1:0]        rob_wr_idx,
  output logic [DATA_W-1:0]       rob_wr_data,
  output logic                    rob_wr_exc,
  output logic [SRC_W-1:0]        rob_wr_src,
  output logic                    idle,
  output logic [15:0]             fill_cnt
);

  // Both sides are valid/ready: a fill transfers on an edge with fill_req[i] &&
  // fill_ack[i]; a ROB write transfers on an edge with rob_wr_en && rob_wr_rdy.

  logic [SRC_W-1:0]  rr;
  logic [SRC_W-1:0]  winner;
  logic              found;
  logic [IDX_W-1:0]  sel_idx;
  logic [DATA_W-1:0] sel_data;
  logic              sel_exc;
  logic              can_load;
  logic              grant;
  logic              rob_done;
  int                c;

  always_comb begin
    found    = 1'b0;
    winner   = '0;
    sel_idx  = '0;
    sel_data = '0;
    sel_exc  = 1'b0;
    c        = 0;
    for (int k = 0; k < N_SRC; k++) begin
      c = int'(rr) + k;
      if (c >= N_SRC) c = c - N_SRC;
      if (!found && fill_req[c]) begin
        found    = 1'b1;
        winner   = SRC_W'(c);
        sel_idx  = fill_idx[c*IDX_W +: IDX_W];
        sel_data = fill_data[c*DATA_W +: DATA_W];
        sel_exc  = fill_exc[c];
      end
    end
  end

  // The stage accepts a new fill when empty or when it drains this same cycle.
  assign can_load = !rob_wr_en || rob_wr_rdy;
  assign grant    = found && can_load && !flush && !rst;
  assign rob_done = rob_wr_en && rob_wr_rdy && !flush;
  assign idle     = !rob_wr_en && !(|fill_req);

  always_comb begin
    fill_ack = '0;
    if (grant) fill_ack[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rob_wr_en   <= 1'b0;
      rob_wr_idx  <= '0;
      rob_wr_data <= '0;
      rob_wr_exc  <= 1'b0;
      rob_wr_src  <= '0;
      fill_cnt    <= '0;
      rr          <= '0;
    end else begin
      if (rob_done) fill_cnt <= fill_cnt + 16'd1;
      if (flush) begin
        rob_wr_en <= 1'b0;
      end else if (grant) begin
        rob_wr_en   <= 1'b1;
        rob_wr_idx  <= sel_idx;
        rob_wr_data <= sel_data;
        rob_wr_exc  <= sel_exc;
        rob_wr_src  <= winner;
      end else if (rob_done) begin
        rob_wr_en <= 1'b0;
      end
      if (grant) rr <= (winner == SRC_W'(N_SRC - 1)) ? '0 : winner + 1'b1;
    end
  end

endmodule

// File: tb/tb_rob_fill_resp.sv
// Directed bench for rob_fill_resp: reset, single fill, round-robin, back-pressure,
// flush, reset mid-operation and fill counter wrap.
module tb_rob_fill_resp;
  localparam int N_SRC  = 3;
  localparam int IDX_W  = 5;
  localparam int DATA_W = 32;
  localparam int SRC_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    flush = 1'b0;
  logic [N_SRC-1:0]        fill_req = '0;
  logic [N_SRC*IDX_W-1:0]  fill_idx = '0;
  logic [N_SRC*DATA_W-1:0] fill_data = '0;
  logic [N_SRC-1:0]        fill_exc = '0;
  logic [N_SRC-1:0]        fill_ack;
  logic                    rob_wr_rdy = 1'b1;
  logic                    rob_wr_en;
  logic [IDX_W-1:0]        rob_wr_idx;
  logic [DATA_W-1:0]       rob_wr_data;
  logic                    rob_wr_exc;
  logic [SRC_W-1:0]        rob_wr_src;
  logic                    idle;
  logic [15:0]             fill_cnt;

  int checks = 0;
  int errors = 0;
  logic [SRC_W-1:0] exp_q[$];

  rob_fill_resp #(.N_SRC(N_SRC), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .fill_req(fill_req), .fill_idx(fill_idx),
    .fill_data(fill_data), .fill_exc(fill_exc), .fill_ack(fill_ack),
    .rob_wr_rdy(rob_wr_rdy), .rob_wr_en(rob_wr_en), .rob_wr_idx(rob_wr_idx),
    .rob_wr_data(rob_wr_data), .rob_wr_exc(rob_wr_exc), .rob_wr_src(rob_wr_src),
    .idle(idle), .fill_cnt(fill_cnt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver tasks; every task starts and ends 1ns after a rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_src(input int i, input logic [IDX_W-1:0] idx,
                         input logic [DATA_W-1:0] data, input logic exc);
    fill_req[i] = 1'b1;
    fill_idx[i*IDX_W +: IDX_W] = idx;
    fill_data[i*DATA_W +: DATA_W] = data;
    fill_exc[i] = exc;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; fill_req = '0; rob_wr_rdy = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fill_req = 3'b111;
    tick(); tick();
    #1;
    checks++; if (fill_ack !== 3'b000) begin errors++; $display("FAIL reset_ack got %b exp 000", fill_ack); end
    checks++; if (rob_wr_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", rob_wr_en); end
    checks++; if (rob_wr_idx !== 5'd0 || rob_wr_data !== 32'd0 || rob_wr_exc !== 1'b0 || rob_wr_src !== 2'd0)
      begin errors++; $display("FAIL reset_fields got %h %h %b %h exp 0", rob_wr_idx, rob_wr_data, rob_wr_exc, rob_wr_src); end
    checks++; if (fill_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", fill_cnt); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL reset_idle_req got %b exp 0", idle); end
    fill_req = '0;
    #1;
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b exp 1", idle); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_fill();
    set_src(1, 5'd5, 32'hDEADBEEF, 1'b0);
    rob_wr_rdy = 1'b1;
    #1;
    checks++; if (fill_ack !== 3'b010) begin errors++; $display("FAIL single_ack got %b exp 010", fill_ack); end
    tick();
    fill_req = '0;
    checks++; if (rob_wr_en !== 1'b1 || rob_wr_idx !== 5'd5 || rob_wr_data !== 32'hDEADBEEF || rob_wr_src !== 2'd1 || rob_wr_exc !== 1'b0)
      begin errors++; $display("FAIL single_write got en=%b idx=%0d data=%h src=%0d exp 1 5 deadbeef 1", rob_wr_en, rob_wr_idx, rob_wr_data, rob_wr_src); end
    checks++; if (fill_cnt !== 16'd0) begin errors++; $display("FAIL single_cnt0 got %0d exp 0", fill_cnt); end
    tick();
    checks++; if (fill_cnt !== 16'd1 || rob_wr_en !== 1'b0) begin errors++; $display("FAIL single_cnt1 got cnt=%0d en=%b exp 1 0", fill_cnt, rob_wr_en); end
  endtask

  task automatic test_round_robin();
    logic [N_SRC-1:0] exp_ack [4];
    logic [SRC_W-1:0] exp_src;
    exp_ack[0] = 3'b001; exp_ack[1] = 3'b010; exp_ack[2] = 3'b100; exp_ack[3] = 3'b001;
    do_reset();
    set_src(0, 5'd10, 32'h0000_00A0, 1'b0);
    set_src(1, 5'd11, 32'h0000_00A1, 1'b0);
    set_src(2, 5'd12, 32'h0000_00A2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (fill_ack !== exp_ack[i]) begin errors++; $display("FAIL rr_ack%0d got %b exp %b", i, fill_ack, exp_ack[i]); end
      exp_q.push_back(SRC_W'(i % 3));
      tick();
      exp_src = exp_q.pop_front();
      checks++; if (rob_wr_en !== 1'b1 || rob_wr_src !== exp_src) begin errors++; $display("FAIL rr_src%0d got en=%b src=%0d exp 1 %0d", i, rob_wr_en, rob_wr_src, exp_src); end
    end
    fill_req = '0;
    tick();
    checks++; if (fill_cnt !== 16'd4) begin errors++; $display("FAIL rr_cnt got %0d exp 4", fill_cnt); end
  endtask

  task automatic test_back_pressure();
    rob_wr_rdy = 1'b1;
    set_src(1, 5'd7, 32'h7777_7777, 1'b0);
    #1;
    checks++; if (fill_ack !== 3'b010) begin errors++; $display("FAIL bp_load_ack got %b exp 010", fill_ack); end
    tick();
    fill_req = '0;
    rob_wr_rdy = 1'b0;
    set_src(0, 5'd9, 32'h9999_0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (fill_ack !== 3'b000 || rob_wr_en !== 1'b1 || rob_wr_idx !== 5'd7)
        begin errors++; $display("FAIL bp_hold%0d got ack=%b en=%b idx=%0d exp 000 1 7", i, fill_ack, rob_wr_en, rob_wr_idx); end
      tick();
    end
    checks++; if (fill_cnt !== 16'd4) begin errors++; $display("FAIL bp_cnt_hold got %0d exp 4", fill_cnt); end
    rob_wr_rdy = 1'b1;
    #1;
    checks++; if (fill_ack !== 3'b001) begin errors++; $display("FAIL bp_release_ack got %b exp 001", fill_ack); end
    tick();
    fill_req = '0;
    checks++; if (rob_wr_idx !== 5'd9 || rob_wr_src !== 2'd0 || fill_cnt !== 16'd5)
      begin errors++; $display("FAIL bp_refill got idx=%0d src=%0d cnt=%0d exp 9 0 5", rob_wr_idx, rob_wr_src, fill_cnt); end
    tick();
    checks++; if (fill_cnt !== 16'd6) begin errors++; $display("FAIL bp_cnt got %0d exp 6", fill_cnt); end
  endtask

  task automatic test_flush();
    set_src(1, 5'd3, 32'h3333_3333, 1'b0);
    tick();
    fill_req = '0;
    checks++; if (rob_wr_en !== 1'b1 || rob_wr_idx !== 5'd3) begin errors++; $display("FAIL flush_load got en=%b idx=%0d exp 1 3", rob_wr_en, rob_wr_idx); end
    flush = 1'b1;
    rob_wr_rdy = 1'b1;
    set_src(2, 5'd20, 32'h2020_2020, 1'b0);
    #1;
    checks++; if (fill_ack !== 3'b000) begin errors++; $display("FAIL flush_ack got %b exp 000", fill_ack); end
    tick();
    flush = 1'b0;
    checks++; if (rob_wr_en !== 1'b0 || fill_cnt !== 16'd6) begin errors++; $display("FAIL flush_kill got en=%b cnt=%0d exp 0 6", rob_wr_en, fill_cnt); end
    // rr must still point at src2, so src2 beats src0
    set_src(0, 5'd21, 32'h2121_2121, 1'b0);
    #1;
    checks++; if (fill_ack !== 3'b100) begin errors++; $display("FAIL flush_rr got %b exp 100", fill_ack); end
    tick();
    fill_req = '0;
    checks++; if (rob_wr_src !== 2'd2 || rob_wr_idx !== 5'd20) begin errors++; $display("FAIL flush_next got src=%0d idx=%0d exp 2 20", rob_wr_src, rob_wr_idx); end
    tick();
    checks++; if (fill_cnt !== 16'd7) begin errors++; $display("FAIL flush_cnt got %0d exp 7", fill_cnt); end
  endtask

  task automatic test_reset_midop();
    set_src(0, 5'd11, 32'hBBBB_0011, 1'b1);
    #1;
    checks++; if (fill_ack !== 3'b001) begin errors++; $display("FAIL mid_load_ack got %b exp 001", fill_ack); end
    tick();
    fill_req = '0;
    rst = 1'b1;
    set_src(1, 5'd12, 32'hCCCC_0012, 1'b0);
    #1;
    checks++; if (fill_ack !== 3'b000) begin errors++; $display("FAIL mid_rst_ack got %b exp 000", fill_ack); end
    tick();
    rst = 1'b0;
    fill_req = '0;
    checks++; if (rob_wr_en !== 1'b0 || rob_wr_idx !== 5'd0 || rob_wr_data !== 32'd0 || rob_wr_exc !== 1'b0 || rob_wr_src !== 2'd0 || fill_cnt !== 16'd0)
      begin errors++; $display("FAIL mid_rst_vals got en=%b idx=%0d data=%h exc=%b src=%0d cnt=%0d exp all 0", rob_wr_en, rob_wr_idx, rob_wr_data, rob_wr_exc, rob_wr_src, fill_cnt); end
    set_src(2, 5'd30, 32'hE0E0_E0E0, 1'b1);
    #1;
    checks++; if (fill_ack !== 3'b100) begin errors++; $display("FAIL mid_src2_ack got %b exp 100", fill_ack); end
    tick();
    fill_req = '0;
    checks++; if (rob_wr_en !== 1'b1 || rob_wr_src !== 2'd2 || rob_wr_exc !== 1'b1 || rob_wr_data !== 32'hE0E0_E0E0)
      begin errors++; $display("FAIL mid_src2_write got en=%b src=%0d exc=%b data=%h exp 1 2 1 e0e0e0e0", rob_wr_en, rob_wr_src, rob_wr_exc, rob_wr_data); end
    tick();
  endtask

  task automatic test_counter_wrap();
    do_reset();
    set_src(0, 5'd1, 32'h1, 1'b0);
    set_src(1, 5'd2, 32'h2, 1'b0);
    set_src(2, 5'd3, 32'h3, 1'b0);
    repeat (65536) @(posedge clk);
    #1;
    checks++; if (fill_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff got %h exp ffff", fill_cnt); end
    tick();
    checks++; if (fill_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h exp 0000", fill_cnt); end
    tick();
    checks++; if (fill_cnt !== 16'h0001) begin errors++; $display("FAIL wrap_one got %h exp 0001", fill_cnt); end
    fill_req = '0;
    tick();
    checks++; if (idle !== 1'b1 || fill_cnt !== 16'h0002) begin errors++; $display("FAIL wrap_drain got idle=%b cnt=%h exp 1 0002", idle, fill_cnt); end
  endtask

  initial begin
    #1;
    test_reset();
    test_single_fill();
    test_round_robin();
    test_back_pressure();
    test_flush();
    test_reset_midop();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
